sketch_reader: RTL and testbench
================================

Name: sketch_reader

Overview:
- Consumer at the output side of the bottom-k sorter in the MinHash datapath.
- On a frame-end pulse, snapshots the sorter's parallel indices_out bus, then streams the valid entries one per beat over a valid/ready interface to the downstream sketch buffer/host.
- Entries are sent in rank order, smallest signature first.
- Tracks the number of samples fed to the sorter, so short frames (fewer than NUM_COMPARATORS samples) emit only the entries that are filled.

Parameters:
- INDEX_WIDTH, 10, width of one index entry.
- NUM_COMPARATORS, 8, sketch depth K (entries in the sorter output).
- LOG_COMPARATORS, 3, clog2(NUM_COMPARATORS).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- frame_start  input  1  pulse; clears the sample counter for a new frame.
- sample_valid  input  1  one sample presented to the sorter this cycle.
- frame_end  input  1  pulse; snapshot indices_in and the sample count, start streaming.
- indices_in  input  NUM_COMPARATORS*INDEX_WIDTH  sorter output, flattened; entry i at [i*INDEX_WIDTH +: INDEX_WIDTH], entry 0 = rank 0 (smallest).
- out_valid  output  1  out_index/out_rank/out_last valid.
- out_ready  input  1  downstream accepts the beat.
- out_index  output  INDEX_WIDTH  current entry.
- out_rank  output  LOG_COMPARATORS  rank of current entry.
- out_last  output  1  final beat of the frame.
- busy  output  1  high while in STREAM.
- frame_done  output  1  one-cycle pulse after the last beat is accepted, or after an empty frame.
- overflow  output  1  sticky; frame_end arrived while busy.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: out_valid=0, out_index=0, out_rank=0, out_last=0, busy=0, frame_done=0, overflow=0.
  - Internal: sample_cnt=0, state=IDLE.
- sample_cnt (LOG_COMPARATORS+1 bits):
  - Increments on sample_valid and saturates at NUM_COMPARATORS.
  - frame_start clears it; frame_start together with sample_valid sets it to 1.
  - frame_end does not clear it.
- Snapshot:
  - On frame_end in IDLE: latch all of indices_in into a shadow register, and latch n = sample_cnt as it was before any same-cycle sample_valid increment.
  - Upstream guarantees that frame_end follows the last sample by at least the sorter latency.
- States:
  - IDLE:
    - frame_end with n>0 -> STREAM, ptr=0.
    - frame_end with n=0 -> stay IDLE, pulse frame_done next cycle, emit no beats.
  - STREAM:
    - out_valid=1, out_index=shadow[ptr], out_rank=ptr, out_last=(ptr==n-1).
    - Beat transfers when out_valid & out_ready.
    - On transfer with out_last -> IDLE, out_valid=0 and frame_done=1 in the next cycle.
    - On any other transfer, ptr increments.
- Latency: first beat valid one cycle after frame_end. With out_ready held high, n beats take n consecutive cycles.
- Handshake:
  - Once out_valid is asserted, out_index/out_rank/out_last stay stable until the beat is accepted.
  - out_valid never drops without a transfer.
  - out_ready may toggle freely.
- Boundaries:
  - frame_end while in STREAM: ignored (shadow unchanged), overflow set to 1 and held until reset.
  - frame_start while in STREAM: clears sample_cnt only; the current stream is unaffected.
  - frame_start and frame_end in the same cycle: the snapshot uses the old count, then the counter clears.
  - Reset mid-stream: immediate return to IDLE and the reset values; no frame_done.
- busy=1 exactly while the state is STREAM.

Optional Feature:
- Macro: SKETCH_READER_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = even parity (XOR reduction) of {out_rank, out_index}.
  - Registered alongside the data, so it is valid under the same out_valid.
  - Reset value 0.
- Undefined: the port is absent; all other behaviour is identical.

Test Plan:
- Full frame: frame_start; 9 samples with sigs 10,8,20,5,15,25,35,45,55 and idx 1..9 into the sorter; frame_end; out_ready=1.
  -> 8 consecutive beats, out_index 4,2,1,5,3,6,7,8, out_rank 0..7, out_last only on rank 7, frame_done 1 cycle later.
- Short frame: frame_start; 3 samples (sigs 10,8,20, idx 1,2,3); frame_end.
  -> 3 beats, indices 2,1,3, out_last on rank 2.
- Empty frame: frame_start then frame_end with no samples.
  -> no out_valid, frame_done pulse one cycle after frame_end.
- Backpressure: full frame with out_ready toggled 1,0,0,1,...
  -> out_index/out_rank held stable while out_ready=0, no beat lost or duplicated, 8 beats total.
- Overflow: second frame_end during beat 3 of a stream.
  -> stream completes unchanged with 8 beats, overflow=1 and held; next frame_end after frame_done is accepted normally.
- Reset mid-stream: assert reset at beat 4.
  -> out_valid, busy and overflow are 0 immediately; no frame_done; a new frame then streams correctly. With SKETCH_READER_PARITY_EN, check out_parity = ^{rank, index} on every beat.

Source files
------------

// File: rtl/sketch_reader.sv
// sketch_reader: snapshots the bottom-k sorter output on frame_end and streams the filled entries,
// smallest signature first, over valid/ready. Define SKETCH_READER_PARITY_EN to add out_parity.
module sketch_reader #(
   parameter int unsigned INDEX_WIDTH     = 10,
   parameter int unsigned NUM_COMPARATORS = 8,
   parameter int unsigned LOG_COMPARATORS = 3
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   frame_start,
   input  logic                                   sample_valid,
   input  logic                                   frame_end,
   input  logic [NUM_COMPARATORS*INDEX_WIDTH-1:0] indices_in,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [INDEX_WIDTH-1:0]                 out_index,
   output logic [LOG_COMPARATORS-1:0]             out_rank,
   output logic                                   out_last,
   output logic                                   busy,
   output logic                                   frame_done,
   output logic                                   overflow
`ifdef SKETCH_READER_PARITY_EN
   ,
   output logic                                   out_parity
`endif
);

   localparam int unsigned CW = LOG_COMPARATORS + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(NUM_COMPARATORS);

   typedef enum logic [0:0] {StIdle, StStream} state_t;

   state_t                   state;
   logic [CW-1:0]            sample_cnt;
   logic [CW-1:0]            n;
   logic [INDEX_WIDTH-1:0]   shadow [NUM_COMPARATORS];
   logic [CW-1:0]            next_ptr;
   logic [INDEX_WIDTH-1:0]   nxt_index;
   logic [LOG_COMPARATORS-1:0] nxt_rank;
   logic                     snapshot;

   // Samples fed to the sorter in this frame, saturating at the sketch depth.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sample_cnt <= '0;
      end else if (frame_start) begin
         sample_cnt <= sample_valid ? CW'(1) : '0;
      end else if (sample_valid && (sample_cnt != CNT_MAX)) begin
         sample_cnt <= sample_cnt + CW'(1);
      end
   end

   assign snapshot = (state == StIdle) && frame_end;

   // Data-only storage; its content is meaningless until the first snapshot.
   always_ff @(posedge clock) begin
      if (snapshot) begin
         for (int i = 0; i < NUM_COMPARATORS; i++) begin
            shadow[i] <= indices_in[i*INDEX_WIDTH +: INDEX_WIDTH];
         end
      end
   end

   assign next_ptr = {1'b0, out_rank} + CW'(1);

   always_comb begin
      nxt_index = '0;
      nxt_rank  = '0;
      if (state == StIdle) begin
         nxt_index = indices_in[0 +: INDEX_WIDTH];
         nxt_rank  = '0;
      end else begin
         nxt_index = shadow[next_ptr[LOG_COMPARATORS-1:0]];
         nxt_rank  = next_ptr[LOG_COMPARATORS-1:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= StIdle;
         n          <= '0;
         out_valid  <= 1'b0;
         out_index  <= '0;
         out_rank   <= '0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
`ifdef SKETCH_READER_PARITY_EN
         out_parity <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         case (state)
            StIdle: begin
               if (frame_end) begin
                  n <= sample_cnt;
                  if (sample_cnt != '0) begin
                     state     <= StStream;
                     busy      <= 1'b1;
                     out_valid <= 1'b1;
                     out_index <= nxt_index;
                     out_rank  <= nxt_rank;
                     out_last  <= (sample_cnt == CW'(1));
`ifdef SKETCH_READER_PARITY_EN
                     out_parity <= ^{nxt_rank, nxt_index};
`endif
                  end else begin
                     frame_done <= 1'b1;
                  end
               end
            end
            StStream: begin
               if (frame_end) begin
                  overflow <= 1'b1;
               end
               if (out_ready) begin
                  if (out_last) begin
                     state      <= StIdle;
                     busy       <= 1'b0;
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     out_index <= nxt_index;
                     out_rank  <= nxt_rank;
                     out_last  <= ((next_ptr + CW'(1)) == n);
`ifdef SKETCH_READER_PARITY_EN
                     out_parity <= ^{nxt_rank, nxt_index};
`endif
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sketch_reader.sv
// Bench for sketch_reader: a bottom-k sorter model feeds indices_in; a scoreboard queue of expected
// beats and frame_done events is drained by an independent monitor.
module tb_sketch_reader;

   localparam int W = 10;
   localparam int K = 8;
   localparam int L = 3;

   logic           clock = 1'b0;
   logic           reset;
   logic           frame_start, sample_valid, frame_end, out_ready;
   logic [K*W-1:0] indices_in;
   logic           out_valid, out_last, busy, frame_done, overflow;
   logic [W-1:0]   out_index;
   logic [L-1:0]   out_rank;
`ifdef SKETCH_READER_PARITY_EN
   logic           out_parity;
`endif

   sketch_reader #(.INDEX_WIDTH(W), .NUM_COMPARATORS(K), .LOG_COMPARATORS(L)) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start), .sample_valid(sample_valid),
      .frame_end(frame_end), .indices_in(indices_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_index(out_index), .out_rank(out_rank), .out_last(out_last),
      .busy(busy), .frame_done(frame_done), .overflow(overflow)
`ifdef SKETCH_READER_PARITY_EN
      , .out_parity(out_parity)
`endif
   );

   always #5 clock = ~clock;

   typedef struct { bit is_done; int idx; int rank; bit last; } ev_t;
   typedef struct { int sig; int idx; } ent_t;

   ev_t  exp_q[$];
   ent_t sorted[$];
   int   samples;
   int   vectors = 0;
   int   miscompares = 0;
   int   beats_seen = 0;
   bit   exp_overflow;
   int   ready_mode;
   int   dsig[9] = '{10, 8, 20, 5, 15, 25, 35, 45, 55};

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_indices();
      logic [W-1:0] v;
      for (int i = 0; i < K; i++) begin
         if (i < sorted.size()) v = W'(sorted[i].idx);
         else v = W'($urandom);
         indices_in[i*W +: W] = v;
      end
   endtask

   // Sorter model: keep the K smallest signatures in ascending order.
   task automatic model_insert(input int sig, input int idx);
      int pos;
      ent_t e;
      pos = sorted.size();
      for (int i = sorted.size() - 1; i >= 0; i--) if (sig < sorted[i].sig) pos = i;
      e.sig = sig;
      e.idx = idx;
      sorted.insert(pos, e);
      if (sorted.size() > K) void'(sorted.pop_back());
      samples++;
   endtask

   task automatic do_start(input bit with_sample, input int sig, input int idx);
      frame_start = 1'b1;
      sample_valid = with_sample;
      tick();
      frame_start = 1'b0;
      sample_valid = 1'b0;
      sorted.delete();
      samples = 0;
      if (with_sample) model_insert(sig, idx);
      drive_indices();
   endtask

   task automatic sample(input int sig, input int idx);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      model_insert(sig, idx);
      drive_indices();
   endtask

   task automatic end_frame(input bit also_start);
      int n;
      n = (samples < K) ? samples : K;
      for (int r = 0; r < n; r++) exp_q.push_back('{0, sorted[r].idx, r, (r == n - 1)});
      exp_q.push_back('{1, 0, 0, 0});
      frame_end = 1'b1;
      frame_start = also_start;
      tick();
      frame_end = 1'b0;
      frame_start = 1'b0;
      if (n > 0) check("first beat latency", out_valid, 1);
      else check("empty frame_done latency", frame_done, 1);
      if (also_start) begin
         samples = 0;
         sorted.delete();
         drive_indices();
      end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 300) begin
         tick();
         cyc++;
      end
      if (exp_q.size() != 0) begin
         check("drain timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      tick();
   endtask

   task automatic wait_beats(input int target);
      int cyc;
      cyc = 0;
      while (beats_seen < target && cyc < 300) begin
         tick();
         cyc++;
      end
      if (beats_seen < target) check("beat wait timeout", beats_seen, target);
   endtask

   // Monitor
   bit           hold_pending = 0;
   logic [W-1:0] h_index;
   logic [L-1:0] h_rank;
   logic         h_last;

   always @(negedge clock) begin
      ev_t e;
      logic [L+W-1:0] pv;
      if (reset) begin
         hold_pending = 0;
      end else begin
         if (hold_pending) begin
            check("valid held", out_valid, 1);
            check("index stable", out_index, h_index);
            check("rank stable", out_rank, h_rank);
            check("last stable", out_last, h_last);
         end
         hold_pending = out_valid && !out_ready;
         h_index = out_index;
         h_rank = out_rank;
         h_last = out_last;
         check("busy tracks stream", busy, out_valid);
         check("overflow", overflow, exp_overflow);
         if (out_valid && out_ready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("beat kind", 0, e.is_done);
               check("out_index", out_index, e.idx);
               check("out_rank", out_rank, e.rank);
               check("out_last", out_last, e.last);
`ifdef SKETCH_READER_PARITY_EN
               pv = {L'(e.rank), W'(e.idx)};
               check("out_parity", out_parity, ^pv);
`endif
            end
         end
         if (frame_done) begin
            if (exp_q.size() == 0) begin
               check("unexpected frame_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("frame_done kind", 1, e.is_done);
            end
         end
      end
   end

   // Ready driver: 0 = always, 1 = pattern 1,0,0, 2 = random
   initial begin
      int pat;
      pat = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         case (ready_mode)
            1: begin out_ready = (pat == 0); pat = (pat + 1) % 3; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
         endcase
      end
   end

   initial begin
      int cyc;
      int base;
      int ns;
      bit chained;
      reset = 1'b1;
      frame_start = 0;
      sample_valid = 0;
      frame_end = 0;
      indices_in = '0;
      ready_mode = 0;
      samples = 0;
      exp_overflow = 0;
      #2;
      check("reset out_valid", out_valid, 0);
      check("reset out_index", out_index, 0);
      check("reset out_rank", out_rank, 0);
      check("reset out_last", out_last, 0);
      check("reset busy", busy, 0);
      check("reset frame_done", frame_done, 0);
      check("reset overflow", overflow, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Full frame, ready held high
      do_start(0, 0, 0);
      for (int i = 0; i < 9; i++) sample(dsig[i], i + 1);
      tick();
      end_frame(0);
      wait_done(cyc);
      check("full frame cycles", cyc, 9);

      // Short frame
      do_start(0, 0, 0);
      for (int i = 0; i < 3; i++) sample(dsig[i], i + 1);
      tick();
      end_frame(0);
      wait_done(cyc);
      check("short frame cycles", cyc, 4);

      // Empty frame
      do_start(0, 0, 0);
      tick();
      end_frame(0);
      wait_done(cyc);

      // Backpressure
      ready_mode = 1;
      do_start(0, 0, 0);
      for (int i = 0; i < 9; i++) sample(dsig[i], i + 1);
      tick();
      end_frame(0);
      wait_done(cyc);

      // Overflow: second frame_end mid-stream with different sorter contents
      ready_mode = 0;
      do_start(0, 0, 0);
      for (int i = 0; i < 9; i++) sample(dsig[i], i + 1);
      tick();
      base = beats_seen;
      end_frame(0);
      wait_beats(base + 3);
      indices_in = {K{W'(1023)}};
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      exp_overflow = 1;
      wait_done(cyc);
      do_start(0, 0, 0);
      for (int i = 0; i < 3; i++) sample(dsig[i], i + 1);
      tick();
      end_frame(0);
      wait_done(cyc);

      // Reset mid-stream
      do_start(0, 0, 0);
      for (int i = 0; i < 9; i++) sample(dsig[i], i + 1);
      tick();
      base = beats_seen;
      end_frame(0);
      wait_beats(base + 4);
      reset = 1'b1;
      #1;
      check("mid reset out_valid", out_valid, 0);
      check("mid reset busy", busy, 0);
      check("mid reset overflow", overflow, 0);
      exp_q.delete();
      exp_overflow = 0;
      samples = 0;
      sorted.delete();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      do_start(0, 0, 0);
      for (int i = 0; i < 9; i++) sample(dsig[i], i + 1);
      tick();
      end_frame(0);
      wait_done(cyc);

      // Randomized frames
      chained = 0;
      for (int f = 0; f < 30; f++) begin
         ready_mode = $urandom_range(0, 2);
         if (!chained) begin
            if ($urandom_range(0, 3) == 0) do_start(1, $urandom_range(0, 1000), $urandom_range(0, 1023));
            else do_start(0, 0, 0);
         end
         ns = $urandom_range(0, 12);
         for (int i = 0; i < ns; i++) begin
            sample($urandom_range(0, 1000), $urandom_range(0, 1023));
            if ($urandom_range(0, 2) == 0) tick();
         end
         tick();
         chained = ($urandom_range(0, 3) == 0);
         end_frame(chained);
         wait_done(cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
